// File: rtl/ps2_key_tracker_if.sv
// ---------------------------------------------------------------------------
// ps2_key_tracker_if
//   Signal bundle between a PS/2 keyboard source and ps2_key_tracker.
//
//   ps2_clk_in   raw PS2_CLK level (asynchronous to the system clock)
//   ps2_data_in  raw PS2_DATA level (asynchronous to the system clock)
//   rec          held-key bitmap of the ten game keys
//   byte_out     last correctly received scancode byte
//   byte_valid   one-cycle pulse when byte_out updates
//   frame_err    one-cycle pulse on a start, parity, stop or timeout error
//
//   master : the keyboard side, drives the PS/2 lines and observes results
//   slave  : the tracker, receives the PS/2 lines and produces results
// ---------------------------------------------------------------------------
interface ps2_key_tracker_if;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic [9:0] rec;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_err;

    modport master (
        output ps2_clk_in,
        output ps2_data_in,
        input  rec,
        input  byte_out,
        input  byte_valid,
        input  frame_err
    );

    modport slave (
        input  ps2_clk_in,
        input  ps2_data_in,
        output rec,
        output byte_out,
        output byte_valid,
        output frame_err
    );
endinterface

// File: rtl/ps2_key_tracker.sv
// ---------------------------------------------------------------------------
// ps2_key_tracker
//   Receive-only PS/2 keyboard front end. Conditions the raw PS/2 clock and
//   data lines (2-FF synchroniser + run-length filter), deserialises 11-bit
//   frames on filtered clock falling edges, and tracks a pressed/released
//   bitmap of ten game keys from the make/break scancode stream.
//
//   Ports:
//     clk   in   system clock (100 MHz)
//     rst   in   asynchronous, active-high reset; clears every register
//     bus   slave modport of ps2_key_tracker_if:
//             ps2_clk_in / ps2_data_in  raw PS/2 lines in
//             rec[9:0]                  held-key bitmap
//                                       [0]=Enter 5A [1]=Space 29 [2]=A 1C
//                                       [3]=S 1B [4]=W 1D [5]=D 23 [6]=1 16
//                                       [7]=2 1E [8]=3 26 [9]=5 2E
//             byte_out[7:0]             last good scancode byte
//             byte_valid                pulse when byte_out updates
//             frame_err                 pulse on any frame error
//
//   Parameters:
//     FILTER_LEN  consecutive equal synchronised samples needed before a
//                 filtered line changes value
//     TIMEOUT     clk cycles without a filtered clock falling edge before an
//                 in-progress frame is abandoned
// ---------------------------------------------------------------------------
module ps2_key_tracker #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic               clk,
    input  logic               rst,
    ps2_key_tracker_if.slave   bus
);

    localparam int         FCW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FCW-1:0] FLIMIT = FCW'(FILTER_LEN - 1);
    localparam logic [16:0]    TO_LIMIT = 17'(TIMEOUT);

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------

    // PS/2 uses odd parity over the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // One-hot position of a tracked scancode in rec; zero for any other code.
    function automatic logic [9:0] key_mask(input logic [7:0] code);
        logic [9:0] m;
        m = 10'b0;
        case (code)
            8'h5A:   m = 10'b00_0000_0001;
            8'h29:   m = 10'b00_0000_0010;
            8'h1C:   m = 10'b00_0000_0100;
            8'h1B:   m = 10'b00_0000_1000;
            8'h1D:   m = 10'b00_0001_0000;
            8'h23:   m = 10'b00_0010_0000;
            8'h16:   m = 10'b00_0100_0000;
            8'h1E:   m = 10'b00_1000_0000;
            8'h26:   m = 10'b01_0000_0000;
            8'h2E:   m = 10'b10_0000_0000;
            default: m = 10'b0;
        endcase
        return m;
    endfunction

    // -----------------------------------------------------------------------
    // Input conditioning. Index 0 is the PS/2 clock, index 1 the PS/2 data.
    // -----------------------------------------------------------------------
    logic [1:0]     meta_r;
    logic [1:0]     sync_r;
    logic [1:0]     filt_r;
    logic [FCW-1:0] fcnt_r [2];
    logic           clk_prev_r;
    logic           fe_s;
    logic           data_s;

    // Synchronise both lines and only accept a new level after FILTER_LEN
    // consecutive samples disagree with the current filtered level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r    <= 2'b11;
            sync_r    <= 2'b11;
            filt_r    <= 2'b11;
            fcnt_r[0] <= '0;
            fcnt_r[1] <= '0;
        end else begin
            meta_r <= {bus.ps2_data_in, bus.ps2_clk_in};
            sync_r <= meta_r;
            for (int i = 0; i < 2; i++) begin
                if (sync_r[i] == filt_r[i]) begin
                    fcnt_r[i] <= '0;
                end else if (fcnt_r[i] == FLIMIT) begin
                    filt_r[i] <= sync_r[i];
                    fcnt_r[i] <= '0;
                end else begin
                    fcnt_r[i] <= fcnt_r[i] + FCW'(1);
                end
            end
        end
    end

    // Remember the previous filtered clock level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_prev_r <= 1'b1;
        end else begin
            clk_prev_r <= filt_r[0];
        end
    end

    assign fe_s   = clk_prev_r & ~filt_r[0];
    assign data_s = filt_r[1];

    // -----------------------------------------------------------------------
    // Frame receiver
    // -----------------------------------------------------------------------
    state_t      state_r, state_n;
    logic [7:0]  shreg_r, shreg_n;
    logic [2:0]  bit_cnt_r, bit_cnt_n;
    logic        par_r, par_n;
    logic [16:0] to_cnt_r;
    logic        timeout_s;
    logic        good_s;
    logic        err_s;

    // Receiver state and shift registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            shreg_r   <= 8'h00;
            bit_cnt_r <= 3'd0;
            par_r     <= 1'b0;
        end else begin
            state_r   <= state_n;
            shreg_r   <= shreg_n;
            bit_cnt_r <= bit_cnt_n;
            par_r     <= par_n;
        end
    end

    // Next-state logic; a falling edge always wins over a coincident timeout
    // because that edge restarts the silence measurement.
    always_comb begin
        state_n   = state_r;
        shreg_n   = shreg_r;
        bit_cnt_n = bit_cnt_r;
        par_n     = par_r;
        good_s    = 1'b0;
        err_s     = 1'b0;
        timeout_s = (state_r != S_IDLE) && (to_cnt_r >= TO_LIMIT);

        if (fe_s) begin
            case (state_r)
                S_IDLE: begin
                    if (!data_s) begin
                        state_n   = S_DATA;
                        bit_cnt_n = 3'd0;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                S_DATA: begin
                    shreg_n = {data_s, shreg_r[7:1]};
                    if (bit_cnt_r == 3'd7) begin
                        state_n   = S_PARITY;
                        bit_cnt_n = 3'd0;
                    end else begin
                        bit_cnt_n = bit_cnt_r + 3'd1;
                    end
                end
                S_PARITY: begin
                    par_n   = data_s;
                    state_n = S_STOP;
                end
                S_STOP: begin
                    state_n = S_IDLE;
                    if (data_s && odd_parity_ok(shreg_r, par_r)) begin
                        good_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end else if (timeout_s) begin
            state_n = S_IDLE;
            err_s   = 1'b1;
        end else begin
            state_n = state_r;
        end
    end

    // Silence counter: idle-cleared, edge-cleared, saturating otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_r <= 17'd0;
        end else if ((state_r == S_IDLE) || fe_s) begin
            to_cnt_r <= 17'd0;
        end else if (to_cnt_r != 17'h1FFFF) begin
            to_cnt_r <= to_cnt_r + 17'd1;
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // -----------------------------------------------------------------------
    // Registered results and scancode decode
    // -----------------------------------------------------------------------
    logic [7:0] byte_out_r;
    logic       byte_valid_r;
    logic       frame_err_r;
    logic [9:0] rec_r;
    logic       brk_r;
    logic       ext_r;
    logic [9:0] mask_s;

    // Result pulses and the captured byte, one cycle after the stop edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_out_r   <= 8'h00;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            byte_valid_r <= good_s;
            frame_err_r  <= err_s;
            if (good_s) begin
                byte_out_r <= shreg_r;
            end else begin
                byte_out_r <= byte_out_r;
            end
        end
    end

    assign mask_s = key_mask(byte_out_r);

    // Prefix tracking and key bitmap update. Extended codes are never mapped
    // so that keypad Enter (E0 5A) cannot alias the main Enter key. A frame
    // error drops both prefixes so a lost F0 cannot turn the next make into
    // a break.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_r <= 10'b0;
            brk_r <= 1'b0;
            ext_r <= 1'b0;
        end else if (byte_valid_r) begin
            if (byte_out_r == CODE_BREAK) begin
                brk_r <= 1'b1;
            end else if (byte_out_r == CODE_EXT) begin
                ext_r <= 1'b1;
            end else begin
                if (!ext_r) begin
                    if (brk_r) begin
                        rec_r <= rec_r & ~mask_s;
                    end else begin
                        rec_r <= rec_r | mask_s;
                    end
                end else begin
                    rec_r <= rec_r;
                end
                brk_r <= 1'b0;
                ext_r <= 1'b0;
            end
        end else if (frame_err_r) begin
            brk_r <= 1'b0;
            ext_r <= 1'b0;
        end else begin
            rec_r <= rec_r;
        end
    end

    assign bus.rec        = rec_r;
    assign bus.byte_out   = byte_out_r;
    assign bus.byte_valid = byte_valid_r;
    assign bus.frame_err  = frame_err_r;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_tracker
//   Drives PS/2 frames from a vector table and a few hand-written sequences.
//   Each frame pushes its expected outcome (good byte or frame error, plus
//   the rec bitmap expected afterwards) into a queue; a monitor pops an entry
//   on each byte_valid / frame_err pulse and checks the byte, that rec has
//   not yet changed in the pulse cycle, and the new rec one cycle later.
// ---------------------------------------------------------------------------
module tb_ps2_key_tracker;

    localparam int HALF = 20;   // PS/2 half bit period in clk cycles

    typedef struct {
        logic [7:0] code;
        logic       bad_par;
        logic       stop;
        logic       glitch;
        logic       is_err;
        logic [9:0] rec;
    } vec_t;

    typedef struct {
        logic       is_err;
        logic [7:0] code;
        logic [9:0] rec;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ps2_key_tracker_if bus_if ();

    ps2_key_tracker #(.FILTER_LEN(8), .TIMEOUT(500)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    exp_t       q [$];
    vec_t       vecs [30];
    logic       pend = 1'b0;
    logic [9:0] pend_rec = 10'b0;
    logic [9:0] last_rec = 10'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampling on the inactive clock edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pend     = 1'b0;
            last_rec = 10'b0;
        end else begin
            if (pend) begin
                check("rec_after", {22'b0, bus_if.rec}, {22'b0, pend_rec});
                pend = 1'b0;
            end
            if (bus_if.byte_valid || bus_if.frame_err) begin
                check("exclusive", {31'b0, bus_if.byte_valid & bus_if.frame_err}, 32'd0);
                if (q.size() == 0) begin
                    check("unexpected_event", {30'b0, bus_if.byte_valid, bus_if.frame_err}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("event_kind", {31'b0, bus_if.frame_err}, {31'b0, e.is_err});
                    if (bus_if.byte_valid) begin
                        check("byte_out", {24'b0, bus_if.byte_out}, {24'b0, e.code});
                    end
                    check("rec_hold", {22'b0, bus_if.rec}, {22'b0, last_rec});
                    pend     = 1'b1;
                    pend_rec = e.rec;
                    last_rec = e.rec;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One PS/2 bit: data set during the high phase, then a low phase.
    task automatic send_bit(input logic b, input logic glitch);
        bus_if.ps2_data_in = b;
        if (glitch) begin
            idle(5);
            bus_if.ps2_clk_in = 1'b0;
            idle(3);
            bus_if.ps2_clk_in = 1'b1;
            idle(HALF - 8);
        end else begin
            idle(HALF);
        end
        bus_if.ps2_clk_in = 1'b0;
        idle(HALF);
        bus_if.ps2_clk_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par,
                              input logic stop, input logic glitch);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i], glitch && (i == 3));
        send_bit((~^code) ^ bad_par, 1'b0);
        send_bit(stop, 1'b0);
        bus_if.ps2_data_in = 1'b1;
        idle(HALF);
    endtask

    task automatic send_partial(input logic [7:0] code, input int nbits);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(code[i], 1'b0);
        bus_if.ps2_data_in = 1'b1;
    endtask

    task automatic push(input logic is_err, input logic [7:0] code, input logic [9:0] r);
        exp_t e;
        e.is_err = is_err;
        e.code   = code;
        e.rec    = r;
        q.push_back(e);
    endtask

    // Wait (bounded) for all expected events to be consumed.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, q.size(), 32'd0);
        idle(3);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            code   badp  stop  glit  err   rec after
        vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 10'h004};  // make A
        vecs[1]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h004};  // break prefix
        vecs[2]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000};  // break A
        vecs[3]  = '{8'h1D, 1'b0, 1'b1, 1'b0, 1'b0, 10'h010};  // make W
        vecs[4]  = '{8'h2E, 1'b0, 1'b1, 1'b0, 1'b0, 10'h210};  // make 5
        vecs[5]  = '{8'h29, 1'b0, 1'b1, 1'b0, 1'b0, 10'h212};  // make Space
        vecs[6]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h212};
        vecs[7]  = '{8'h1D, 1'b0, 1'b1, 1'b0, 1'b0, 10'h202};  // break W
        vecs[8]  = '{8'h1D, 1'b0, 1'b1, 1'b0, 1'b0, 10'h212};  // typematic W
        vecs[9]  = '{8'h1D, 1'b0, 1'b1, 1'b0, 1'b0, 10'h212};
        vecs[10] = '{8'h1D, 1'b0, 1'b1, 1'b0, 1'b0, 10'h212};
        vecs[11] = '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h212};  // keypad Enter
        vecs[12] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 10'h212};
        vecs[13] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 10'h213};  // main Enter
        vecs[14] = '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h213};  // keypad Enter up
        vecs[15] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h213};
        vecs[16] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 10'h213};
        vecs[17] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 10'h213};  // parity error
        vecs[18] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 10'h213};  // stop error
        vecs[19] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h213};
        vecs[20] = '{8'hF0, 1'b1, 1'b1, 1'b0, 1'b1, 10'h213};  // dropped F0
        vecs[21] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 10'h217};  // acts as make
        vecs[22] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h217};
        vecs[23] = '{8'h29, 1'b1, 1'b1, 1'b0, 1'b1, 10'h217};  // error drops brk
        vecs[24] = '{8'h29, 1'b0, 1'b1, 1'b0, 1'b0, 10'h217};  // still a make
        vecs[25] = '{8'h26, 1'b0, 1'b1, 1'b1, 1'b0, 10'h317};  // glitch mid-frame
        vecs[26] = '{8'h1E, 1'b0, 1'b1, 1'b0, 1'b0, 10'h397};
        vecs[27] = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 10'h397};  // unmapped
        vecs[28] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h397};
        vecs[29] = '{8'h1E, 1'b0, 1'b1, 1'b0, 1'b0, 10'h317};

        bus_if.ps2_clk_in  = 1'b1;
        bus_if.ps2_data_in = 1'b1;
        rst = 1'b1;
        idle(4);
        check("reset_rec",        {22'b0, bus_if.rec},        32'd0);
        check("reset_byte_out",   {24'b0, bus_if.byte_out},   32'd0);
        check("reset_byte_valid", {31'b0, bus_if.byte_valid}, 32'd0);
        check("reset_frame_err",  {31'b0, bus_if.frame_err},  32'd0);
        rst = 1'b0;
        idle(5);

        // Idle glitch: three low cycles must not produce any event.
        bus_if.ps2_clk_in = 1'b0;
        idle(3);
        bus_if.ps2_clk_in = 1'b1;
        idle(40);

        for (int i = 0; i < 30; i++) begin
            push(vecs[i].is_err, vecs[i].code, vecs[i].rec);
            send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].stop, vecs[i].glitch);
            drain("frame_done");
        end

        // Stray clock pulse with data high: start-bit error.
        push(1'b1, 8'h00, 10'h317);
        send_bit(1'b1, 1'b0);
        drain("start_err");

        // Timeout after bit 4, with a pending break prefix that must be dropped.
        push(1'b0, 8'hF0, 10'h317);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        drain("pre_timeout");
        push(1'b1, 8'h00, 10'h317);
        send_partial(8'h2E, 5);
        drain("timeout_err");
        push(1'b0, 8'h1D, 10'h317);
        send_frame(8'h1D, 1'b0, 1'b1, 1'b0);
        drain("post_timeout");

        // Asynchronous reset in the middle of a frame.
        send_partial(8'h1D, 6);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rec",        {22'b0, bus_if.rec},        32'd0);
        check("async_byte_out",   {24'b0, bus_if.byte_out},   32'd0);
        check("async_byte_valid", {31'b0, bus_if.byte_valid}, 32'd0);
        check("async_frame_err",  {31'b0, bus_if.frame_err},  32'd0);
        idle(5);
        rst = 1'b0;
        idle(5);
        push(1'b0, 8'h1D, 10'h010);
        send_frame(8'h1D, 1'b0, 1'b1, 1'b0);
        drain("post_reset");

        check("queue_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
